// File: rtl/udp_rx_parser.sv
// udp_rx_parser
//   Byte-wide Ethernet/IPv4/UDP receive filter. Checks dest MAC (local or
//   broadcast), ethertype, IPv4 version/IHL, protocol, dest IP, and UDP dest
//   port/length. Forwards the UDP payload of accepted frames and reports one
//   status pulse per frame.
// Ports
//   clk, rst          byte clock, synchronous active-high reset
//   I_rx_de/data      input byte stream (preamble/SFD stripped, FCS included)
//   I_rx_sof/eof      frame delimiters, qualified by I_rx_de
//   I_rx_crc_err      MAC CRC verdict, sampled with I_rx_eof
//   O_udp_data/de/sof/eof        payload stream, 1 cycle after the input byte
//   O_udp_data_len/ipv4_sign/src_port  header fields of the last accepted frame
//   O_frame_good/drop, O_udp_err single-cycle status pulses
module udp_rx_parser #(
  parameter logic [47:0] LOCAL_MAC  = 48'h06_00_AA_BB_0C_DD,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0F0E,
  parameter logic [15:0] LOCAL_PORT = 16'd8080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        I_rx_de,
  input  logic [7:0]  I_rx_data,
  input  logic        I_rx_sof,
  input  logic        I_rx_eof,
  input  logic        I_rx_crc_err,
  output logic [7:0]  O_udp_data,
  output logic        O_udp_de,
  output logic        O_udp_sof,
  output logic        O_udp_eof,
  output logic [15:0] O_udp_data_len,
  output logic [15:0] O_ipv4_sign,
  output logic [15:0] O_src_port,
  output logic        O_frame_good,
  output logic        O_frame_drop,
  output logic        O_udp_err
);

  typedef enum logic [2:0] {IDLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TAIL, DROP} state_e;

  state_e      state_q, state_d, st;
  logic [10:0] cnt_q, cnt_d, idx;
  logic        ucast_q, ucast_d, bcast_q, bcast_d, ucast_c, bcast_c;
  logic [15:0] hid_q, hid_d, hsport_q, hsport_d, hlen_q, hlen_d, len_new;
  logic [15:0] rem_q, rem_d;
  logic        first_q, first_d;
  logic        hdr_bad;

  logic [7:0]  data_q, data_d;
  logic        de_q, de_d, sof_q, sof_d, eof_q, eof_d;
  logic [15:0] len_q, len_d, id_q, id_d, sport_q, sport_d;
  logic        good_q, good_d, drop_q, drop_d, err_q, err_d;

  // A start-of-frame byte always restarts parsing as byte 0 of ETH_HDR,
  // whatever state the previous frame was left in.
  assign st  = I_rx_sof ? ETH_HDR : state_q;
  assign idx = I_rx_sof ? 11'd0 : cnt_q;

  // Header bytes with a fixed expected value. MAC bytes are flagged
  // separately since they may also match broadcast.
  logic [7:0] exp_b;
  logic       mac_b, fix_b;
  always_comb begin
    exp_b = 8'h00;
    mac_b = 1'b0;
    fix_b = 1'b0;
    case (idx)
      11'd0:  begin mac_b = 1'b1; exp_b = LOCAL_MAC[47:40]; end
      11'd1:  begin mac_b = 1'b1; exp_b = LOCAL_MAC[39:32]; end
      11'd2:  begin mac_b = 1'b1; exp_b = LOCAL_MAC[31:24]; end
      11'd3:  begin mac_b = 1'b1; exp_b = LOCAL_MAC[23:16]; end
      11'd4:  begin mac_b = 1'b1; exp_b = LOCAL_MAC[15:8];  end
      11'd5:  begin mac_b = 1'b1; exp_b = LOCAL_MAC[7:0];   end
      11'd12: begin fix_b = 1'b1; exp_b = 8'h08; end
      11'd13: begin fix_b = 1'b1; exp_b = 8'h00; end
      11'd14: begin fix_b = 1'b1; exp_b = 8'h45; end
      11'd23: begin fix_b = 1'b1; exp_b = 8'h11; end
      11'd30: begin fix_b = 1'b1; exp_b = LOCAL_IP[31:24]; end
      11'd31: begin fix_b = 1'b1; exp_b = LOCAL_IP[23:16]; end
      11'd32: begin fix_b = 1'b1; exp_b = LOCAL_IP[15:8];  end
      11'd33: begin fix_b = 1'b1; exp_b = LOCAL_IP[7:0];   end
      11'd36: begin fix_b = 1'b1; exp_b = LOCAL_PORT[15:8]; end
      11'd37: begin fix_b = 1'b1; exp_b = LOCAL_PORT[7:0];  end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ucast_d  = ucast_q;
    bcast_d  = bcast_q;
    hid_d    = hid_q;
    hsport_d = hsport_q;
    hlen_d   = hlen_q;
    rem_d    = rem_q;
    first_d  = first_q;
    data_d   = data_q;
    de_d     = 1'b0;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    len_d    = len_q;
    id_d     = id_q;
    sport_d  = sport_q;
    good_d   = 1'b0;
    drop_d   = 1'b0;
    err_d    = 1'b0;
    hdr_bad  = 1'b0;
    ucast_c  = I_rx_sof | ucast_q;
    bcast_c  = I_rx_sof | bcast_q;
    len_new  = {hlen_q[15:8], I_rx_data};

    if (I_rx_de) begin
      cnt_d = (idx == 11'h7FF) ? idx : idx + 11'd1;
      if (I_rx_sof) begin
        state_d = ETH_HDR;
        // A new frame cutting into a payload is reported as a UDP error.
        if (state_q == PAYLOAD) err_d = 1'b1;
      end
      case (st)
        ETH_HDR, IP_HDR, UDP_HDR: begin
          if (mac_b) begin
            ucast_d = ucast_c & (I_rx_data == exp_b);
            bcast_d = bcast_c & (I_rx_data == 8'hFF);
            if (!ucast_d && !bcast_d) hdr_bad = 1'b1;
          end
          if (fix_b && (I_rx_data != exp_b)) hdr_bad = 1'b1;
          case (idx)
            11'd18: hid_d[15:8]    = I_rx_data;
            11'd19: hid_d[7:0]     = I_rx_data;
            11'd34: hsport_d[15:8] = I_rx_data;
            11'd35: hsport_d[7:0]  = I_rx_data;
            11'd38: hlen_d[15:8]   = I_rx_data;
            11'd39: begin
              hlen_d = len_new;
              if (len_new < 16'd8) hdr_bad = 1'b1;
            end
            default: ;
          endcase
          if (I_rx_eof) begin
            drop_d  = 1'b1;
            state_d = IDLE;
          end else if (hdr_bad) begin
            state_d = DROP;
          end else if (idx == 11'd13) begin
            state_d = IP_HDR;
          end else if (idx == 11'd33) begin
            state_d = UDP_HDR;
          end else if (idx == 11'd41) begin
            // Header accepted: publish fields, length >= 8 already enforced.
            len_d   = hlen_q - 16'd8;
            id_d    = hid_q;
            sport_d = hsport_q;
            rem_d   = hlen_q - 16'd8;
            first_d = 1'b1;
            state_d = (hlen_q == 16'd8) ? TAIL : PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (I_rx_eof && (rem_q != 16'd1)) begin
            // Frame ended short: the eof byte is not forwarded.
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            de_d    = 1'b1;
            data_d  = I_rx_data;
            sof_d   = first_q;
            first_d = 1'b0;
            eof_d   = (rem_q == 16'd1);
            rem_d   = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              if (I_rx_eof) begin
                // No padding/FCS after the payload: judge the frame now.
                good_d  = ~I_rx_crc_err;
                err_d   = I_rx_crc_err;
                state_d = IDLE;
              end else begin
                state_d = TAIL;
              end
            end
          end
        end
        TAIL: begin
          if (I_rx_eof) begin
            good_d  = ~I_rx_crc_err;
            err_d   = I_rx_crc_err;
            state_d = IDLE;
          end
        end
        DROP: begin
          if (I_rx_eof) begin
            drop_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: cnt_d = cnt_q;  // IDLE: stray bytes are ignored
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 11'd0;
      ucast_q  <= 1'b0;
      bcast_q  <= 1'b0;
      hid_q    <= 16'd0;
      hsport_q <= 16'd0;
      hlen_q   <= 16'd0;
      rem_q    <= 16'd0;
      first_q  <= 1'b0;
      data_q   <= 8'd0;
      de_q     <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      len_q    <= 16'd0;
      id_q     <= 16'd0;
      sport_q  <= 16'd0;
      good_q   <= 1'b0;
      drop_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ucast_q  <= ucast_d;
      bcast_q  <= bcast_d;
      hid_q    <= hid_d;
      hsport_q <= hsport_d;
      hlen_q   <= hlen_d;
      rem_q    <= rem_d;
      first_q  <= first_d;
      data_q   <= data_d;
      de_q     <= de_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      len_q    <= len_d;
      id_q     <= id_d;
      sport_q  <= sport_d;
      good_q   <= good_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
    end
  end

  assign O_udp_data     = data_q;
  assign O_udp_de       = de_q;
  assign O_udp_sof      = sof_q;
  assign O_udp_eof      = eof_q;
  assign O_udp_data_len = len_q;
  assign O_ipv4_sign    = id_q;
  assign O_src_port     = sport_q;
  assign O_frame_good   = good_q;
  assign O_frame_drop   = drop_q;
  assign O_udp_err      = err_q;

endmodule
